// File: rtl/pwm_multi_pkg.sv
// pwm_multi shared definitions: register map, CTRL layout, byte-enable helpers.
package pwm_multi_pkg;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_DIV    = 4'h4;
   localparam logic [3:0] OFF_PERIOD = 4'h8;
   localparam logic [3:0] OFF_DUTY   = 4'hC;

   localparam logic [7:0] ADDR_IRQ_STAT = 8'h80;
   localparam logic [7:0] ADDR_IRQ_EN   = 8'h84;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_OE     = 1;
   localparam int CTRL_INV    = 2;
   localparam int CTRL_CALIGN = 3;

   typedef struct packed {
      logic calign;
      logic inv;
      logic oe;
      logic en;
   } ctrl_t;

   function automatic logic [31:0] be_mask(logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi register bus: strobes, byte address, write data, byte enables
// and the combinational read data returned by the peripheral.
interface pwm_multi_if;
   logic        re_i;
   logic        we_i;
   logic [7:0]  addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic [31:0] rdata_o;

   modport master (output re_i, we_i, addr_i, wdata_i, be_i,
                   input  rdata_o);
   modport slave  (input  re_i, we_i, addr_i, wdata_i, be_i,
                   output rdata_o);
endinterface

// File: rtl/pwm_multi_chan.sv
// One PWM channel: prescaler, up or up/down counter, shadow-to-active
// reload at the period boundary, and polarity-adjusted output.
module pwm_multi_chan #(
   parameter int CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en,
   input  logic          inv,
   input  logic          calign,
   input  logic [CW-1:0] div_s,
   input  logic [CW-1:0] per_s,
   input  logic [CW-1:0] duty_s,
   output logic          pwm,
   output logic          period_end
);

   logic [CW-1:0] div_a, per_a, duty_a;
   logic [CW-1:0] psc, cnt, cnt_nx, div_m1;
   logic          down, down_nx, tick, pe, raw;

   assign div_m1 = (div_a == '0) ? '0 : div_a - 1'b1;
   assign tick   = en && (psc == div_m1);

   // Centre mode dwells one tick at each end so the period is 2*PERIOD ticks.
   always_comb begin
      cnt_nx  = cnt;
      down_nx = down;
      pe      = 1'b0;
      if (tick) begin
         if (per_a == '0) begin
            cnt_nx  = '0;
            down_nx = 1'b0;
            pe      = 1'b1;
         end else if (!calign) begin
            if (cnt >= per_a - 1'b1) begin
               cnt_nx = '0;
               pe     = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end else if (!down) begin
            if (cnt >= per_a - 1'b1) down_nx = 1'b1;
            else                     cnt_nx  = cnt + 1'b1;
         end else begin
            if (cnt == '0) begin
               down_nx = 1'b0;
               pe      = 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         psc    <= '0;
         cnt    <= '0;
         down   <= 1'b0;
         div_a  <= '0;
         per_a  <= '0;
         duty_a <= '0;
      end else if (!en) begin
         psc    <= '0;
         cnt    <= '0;
         down   <= 1'b0;
         div_a  <= div_s;
         per_a  <= per_s;
         duty_a <= duty_s;
      end else begin
         psc  <= tick ? '0 : psc + 1'b1;
         cnt  <= cnt_nx;
         down <= down_nx;
         if (pe) begin
            div_a  <= div_s;
            per_a  <= per_s;
            duty_a <= duty_s;
         end
      end
   end

   assign raw = (per_a != '0) && (duty_a != '0) &&
                ((duty_a >= per_a) || (cnt < duty_a));

   assign pwm        = en ? (raw ^ inv) : inv;
   assign period_end = pe;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM peripheral: register file, decode, read mux, channels.
// Define PWM_IRQ_EN to add IRQ_STAT/IRQ_EN and the period-end interrupt.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   pwm_multi_if.slave     bus,
   output logic [NCH-1:0] pwm_o,
   output logic [NCH-1:0] oe_o,
   output logic           intr_o
);

   ctrl_t          ctrl   [NCH];
   logic [CW-1:0]  div_s  [NCH];
   logic [CW-1:0]  per_s  [NCH];
   logic [CW-1:0]  duty_s [NCH];
   logic [NCH-1:0] sel, pe;
   logic [31:0]    rd, irq_rd, bmask, merged;
   logic [3:0]     off;
   logic           wr;

   assign wr     = bus.we_i & ~bus.re_i;
   assign off    = bus.addr_i[3:0];
   assign bmask  = be_mask(bus.be_i);
   // Byte-enabled writes merge into the current register value.
   assign merged = (rd & ~bmask) | (bus.wdata_i & bmask);

   always_comb begin
      sel = '0;
      for (int c = 0; c < NCH; c++) begin
         sel[c] = !bus.addr_i[7] && (bus.addr_i[1:0] == 2'b00) &&
                  ({29'd0, bus.addr_i[6:4]} == c);
      end
   end

   always_comb begin
      rd = '0;
      if (bus.addr_i[7]) begin
         rd = irq_rd;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (sel[c]) begin
               case (off)
                  OFF_CTRL:   rd = {28'd0, ctrl[c]};
                  OFF_DIV:    rd = 32'(div_s[c]);
                  OFF_PERIOD: rd = 32'(per_s[c]);
                  OFF_DUTY:   rd = 32'(duty_s[c]);
                  default:    rd = '0;
               endcase
            end
         end
      end
   end

   assign bus.rdata_o = rd;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NCH; c++) begin
            ctrl[c]   <= '0;
            div_s[c]  <= '0;
            per_s[c]  <= '0;
            duty_s[c] <= '0;
         end
      end else if (wr) begin
         for (int c = 0; c < NCH; c++) begin
            if (sel[c]) begin
               case (off)
                  OFF_CTRL:   ctrl[c]   <= ctrl_t'(merged[3:0]);
                  OFF_DIV:    div_s[c]  <= merged[CW-1:0];
                  OFF_PERIOD: per_s[c]  <= merged[CW-1:0];
                  OFF_DUTY:   duty_s[c] <= merged[CW-1:0];
                  default:    ;
               endcase
            end
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      pwm_multi_chan #(.CW(CW)) u_chan (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .en         (ctrl[c].en),
         .inv        (ctrl[c].inv),
         .calign     (ctrl[c].calign),
         .div_s      (div_s[c]),
         .per_s      (per_s[c]),
         .duty_s     (duty_s[c]),
         .pwm        (pwm_o[c]),
         .period_end (pe[c])
      );
      assign oe_o[c] = ctrl[c].oe;
   end

`ifdef PWM_IRQ_EN
   logic [NCH-1:0] irq_stat, irq_en, clr;
   logic           irq_q;

   assign clr = (wr && bus.addr_i == ADDR_IRQ_STAT) ?
                merged[NCH-1:0] & ~rd[NCH-1:0] | (bus.wdata_i[NCH-1:0] & bmask[NCH-1:0]) :
                '0;

   always_comb begin
      irq_rd = '0;
      if (bus.addr_i == ADDR_IRQ_STAT) irq_rd = 32'(irq_stat);
      else if (bus.addr_i == ADDR_IRQ_EN) irq_rd = 32'(irq_en);
   end

   // A period end in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_stat <= '0;
         irq_en   <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_stat <= (irq_stat & ~clr) | pe;
         if (wr && bus.addr_i == ADDR_IRQ_EN) irq_en <= merged[NCH-1:0];
         irq_q <= |(irq_stat & irq_en);
      end
   end

   assign intr_o = irq_q;
`else
   logic unused_pe;
   assign unused_pe = ^pe;
   assign irq_rd    = '0;
   assign intr_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: register table plus waveform sequences.
// Define PWM_IRQ_EN when building the design with the interrupt block.
module tb_pwm_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] pwm, oe;
   logic       intr;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic wave [64];
   logic expw [64];

`ifdef PWM_IRQ_EN
   localparam logic [31:0] IRQ_EN_RB = 32'hF;
`else
   localparam logic [31:0] IRQ_EN_RB = 32'h0;
`endif

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t vq[$];

   pwm_multi_if bus();

   pwm_multi #(.NCH(4), .CW(16)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .pwm_o  (pwm),
      .oe_o   (oe),
      .intr_o (intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_wave(input string nm, input int n);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < n; i++) begin
         if (wave[i] !== expw[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      vec_cnt++;
      if (bad != 0) begin
         err_cnt++;
         $display("FAIL %s: %0d cycles differ, first at %0d got %b want %b",
                  nm, bad, first, wave[first], expw[first]);
      end
   endtask

   task automatic wrb(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      bus.we_i    = 1'b1;
      bus.addr_i  = a;
      bus.wdata_i = d;
      bus.be_i    = be;
      @(posedge clk);
      #1;
      bus.we_i = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wrb(a, d, 4'hF);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bus.addr_i = a;
      bus.re_i   = 1'b1;
      #1;
      d = bus.rdata_o;
      bus.re_i = 1'b0;
   endtask

   // Sample one channel per cycle; optionally inject a register write
   // so that it lands on the edge right after sample wr_at.
   task automatic run_wave(input int ch, input int n, input int wr_at,
                           input logic [7:0] wa, input logic [31:0] wd);
      for (int i = 0; i < n; i++) begin
         wave[i] = pwm[ch];
         if (i == wr_at) begin
            bus.we_i    = 1'b1;
            bus.addr_i  = wa;
            bus.wdata_i = wd;
            bus.be_i    = 4'hF;
         end else begin
            bus.we_i = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.we_i = 1'b0;
   endtask

   task automatic push(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] e);
      vec_t v;
      v.wr = w; v.addr = a; v.data = d; v.be = be; v.exp = e;
      vq.push_back(v);
   endtask

   initial begin
      logic [31:0] r;

      rst_n       = 1'b0;
      bus.re_i    = 1'b0;
      bus.we_i    = 1'b0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.be_i    = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      chk("reset pwm", 32'(pwm), 0);
      chk("reset oe", 32'(oe), 0);
      chk("reset intr", 32'(intr), 0);

      for (int c = 0; c < 4; c++)
         for (int o = 0; o < 16; o += 4)
            push(0, 8'(16 * c + o), 0, 0, 0);
      push(0, 8'h80, 0, 0, 0);
      push(0, 8'h84, 0, 0, 0);
      push(1, 8'h34, 32'h1234,  4'hF, 0);
      push(0, 8'h34, 0, 0, 32'h1234);
      push(1, 8'h34, 32'hFFFF,  4'h1, 0);
      push(0, 8'h34, 0, 0, 32'h12FF);
      push(1, 8'h38, 32'hABCDE, 4'hF, 0);
      push(0, 8'h38, 0, 0, 32'hBCDE);
      push(1, 8'h3C, 32'h55,    4'hF, 0);
      push(0, 8'h3C, 0, 0, 32'h55);
      push(1, 8'h30, 32'hF,     4'h2, 0);
      push(0, 8'h30, 0, 0, 32'h0);
      push(1, 8'h30, 32'hFF,    4'h1, 0);
      push(0, 8'h30, 0, 0, 32'hF);
      push(1, 8'h32, 32'hFFFF,  4'hF, 0);
      push(0, 8'h32, 0, 0, 32'h0);
      push(1, 8'h54, 32'hFFFF,  4'hF, 0);
      push(0, 8'h54, 0, 0, 32'h0);
      push(1, 8'h80, 32'hFFFFFFFF, 4'hF, 0);
      push(0, 8'h80, 0, 0, 32'h0);
      push(1, 8'h84, 32'hFF,    4'hF, 0);
      push(0, 8'h84, 0, 0, IRQ_EN_RB);

      foreach (vq[k]) begin
         if (vq[k].wr) begin
            wrb(vq[k].addr, vq[k].data, vq[k].be);
         end else begin
            rd(vq[k].addr, r);
            chk($sformatf("reg %02h", vq[k].addr), r, vq[k].exp);
         end
      end
      chk("oe ch3", 32'(oe), 32'h8);
      wr(8'h30, 0);
      wr(8'h84, 0);

      // ch0 edge-aligned DIV=2 PERIOD=10 DUTY=3
      wr(8'h04, 2);
      wr(8'h08, 10);
      wr(8'h0C, 3);
      wr(8'h00, 3);
      run_wave(0, 40, -1, 0, 0);
      for (int i = 0; i < 40; i++) expw[i] = (i % 20) < 6;
      chk_wave("ch0 edge", 40);
      chk("oe ch0", 32'(oe[0]), 1);

      wr(8'h0C, 3);
      wr(8'h00, 0);
      chk("en off inactive", 32'(pwm[0]), 0);
      wr(8'h00, 3);
      run_wave(0, 60, 2, 8'h0C, 7);
      for (int i = 0; i < 60; i++) expw[i] = (i % 20) < (i < 20 ? 6 : 14);
      chk_wave("ch0 duty mid-period", 60);

      wr(8'h0C, 3);
      wr(8'h00, 0);
      wr(8'h00, 3);
      run_wave(0, 60, 19, 8'h0C, 7);
      for (int i = 0; i < 60; i++) expw[i] = (i % 20) < (i < 40 ? 6 : 14);
      chk_wave("ch0 write at period end", 60);

      // ch1 centre-aligned DIV=1 PERIOD=4 DUTY=2
      wr(8'h14, 1);
      wr(8'h18, 4);
      wr(8'h1C, 2);
      wr(8'h10, 9);
      run_wave(1, 32, -1, 0, 0);
      for (int i = 0; i < 32; i++) expw[i] = ((i % 8) < 2) || ((i % 8) >= 6);
      chk_wave("ch1 centre", 32);
      chk("oe ch1", 32'(oe[1]), 0);

      wr(8'h28, 5);
      wr(8'h2C, 5);
      wr(8'h20, 1);
      run_wave(2, 24, -1, 0, 0);
      for (int i = 0; i < 24; i++) expw[i] = 1'b1;
      chk_wave("ch2 duty=period", 24);

      wr(8'h20, 0);
      wr(8'h28, 0);
      wr(8'h2C, 3);
      wr(8'h20, 1);
      run_wave(2, 16, -1, 0, 0);
      for (int i = 0; i < 16; i++) expw[i] = 1'b0;
      chk_wave("ch2 period=0", 16);

      wr(8'h20, 5);
      run_wave(2, 8, -1, 0, 0);
      for (int i = 0; i < 8; i++) expw[i] = 1'b1;
      chk_wave("ch2 period=0 inv", 8);

      wr(8'h20, 4);
      chk("ch2 inv disabled", 32'(pwm[2]), 1);

      wr(8'h20, 0);
      wr(8'h28, 5);
      wr(8'h2C, 0);
      wr(8'h20, 1);
      run_wave(2, 16, -1, 0, 0);
      for (int i = 0; i < 16; i++) expw[i] = 1'b0;
      chk_wave("ch2 duty=0", 16);

      wr(8'h20, 0);
      wr(8'h28, 4);
      wr(8'h2C, 1);
      wr(8'h20, 1);
      run_wave(2, 16, -1, 0, 0);
      for (int i = 0; i < 16; i++) expw[i] = (i % 4) == 0;
      chk_wave("ch2 div=0", 16);

`ifdef PWM_IRQ_EN
      wr(8'h0C, 3);
      wr(8'h00, 0);
      wr(8'h84, 1);
      wr(8'h80, 32'hFF);
      wr(8'h00, 3);
      bus.addr_i = 8'h80;
      for (int i = 0; i < 24; i++) begin
         #1;
         if (i == 19) chk("irq stat before end", 32'(bus.rdata_o[0]), 0);
         if (i == 20) begin
            chk("irq stat at end", 32'(bus.rdata_o[0]), 1);
            chk("intr not yet", 32'(intr), 0);
         end
         if (i == 21) chk("intr raised", 32'(intr), 1);
         @(posedge clk);
         #1;
      end
      wr(8'h80, 1);
      rd(8'h80, r);
      chk("irq stat w1c", 32'(r[0]), 0);
      @(posedge clk);
      #1;
      chk("intr cleared", 32'(intr), 0);
`else
      wr(8'h84, 1);
      repeat (25) @(posedge clk);
      #1;
      chk("intr tied low", 32'(intr), 0);
      rd(8'h80, r);
      chk("irq stat absent", r, 0);
`endif

      wr(8'h00, 0);
      wr(8'h00, 3);
      chk("ch0 high before reset", 32'(pwm[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset pwm", 32'(pwm), 0);
      chk("async reset oe", 32'(oe), 0);
      rd(8'h08, r);
      chk("async reset period", r, 0);
      #2 rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
